// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch stage requests a word
//   imem_addr  : word address, held stable while imem_req is high
//   imem_ack   : request completes at this edge, imem_rdata valid
//   imem_rdata : instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage.
// Owns the fetch PC, issues word requests over a req/ack bus that tolerates
// wait states, and presents one instruction per cycle to IF/ID. Handles
// hazard stalls and decode redirects, including redirects that land while a
// request is still outstanding (the old request is completed and discarded).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : IF/ID will not take the presented instruction
//   redirect/_pc        : taken branch / jump target (bits [1:0] ignored)
//   imem                : instruction-memory bus (master side)
//   instruction         : presented word, 0 whenever inst_valid=0
//   inst_valid          : presented word is real
//   inst_pc, pc_plus4   : address of presented word and that address + 4
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_stage_if.master      imem,
    output logic [31:0]        instruction,
    output logic               inst_valid,
    output logic [31:0]        inst_pc,
    output logic [31:0]        pc_plus4
);

    // BUSY: request outstanding on the right path.
    // DROP: request outstanding whose data must be thrown away.
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pend_pc, tgt;
    logic        issue, req, ack_edge, take;

    assign tgt = {redirect_pc[31:2], 2'b00};

    always_comb begin
        // Only start a request when the output slot is empty or draining,
        // so an ack can always be written without a skid buffer.
        issue    = (state == IDLE) && !redirect && (!inst_valid || !stall);
        req      = !rst && ((state != IDLE) || issue);
        ack_edge = req && imem.imem_ack;
        take     = ack_edge && (state != DROP) && !redirect;
        state_nx = state;
        if (ack_edge)
            state_nx = IDLE;
        else if (req)
            state_nx = (redirect || state == DROP) ? DROP : BUSY;
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend_pc     <= 32'h0;
            instruction <= 32'h0;
            inst_valid  <= 1'b0;
            inst_pc     <= 32'h0;
            pc_plus4    <= 32'h0;
        end else begin
            // pc only moves when no request is outstanding after this edge.
            if (ack_edge)
                pc <= take ? pc + 32'd4 : (redirect ? tgt : pend_pc);
            else if (redirect && !req)
                pc <= tgt;

            // Latest redirect seen while waiting on a wrong-path ack wins.
            if (req && !imem.imem_ack && redirect)
                pend_pc <= tgt;

            if (take) begin
                instruction <= imem.imem_rdata;
                inst_valid  <= 1'b1;
                inst_pc     <= pc;
                pc_plus4    <= pc + 32'd4;
            end else if (redirect || (inst_valid && !stall)) begin
                // Redirect kills the wrong-path word even under stall.
                instruction <= 32'h0;
                inst_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- DUT0: RESET_PC = 0, programmable wait states
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction, inst_pc, pc_plus4;
    logic        inst_valid;
    int          wait_n, cnt0;

    fetch_stage_if bus0();

    assign bus0.imem_ack   = bus0.imem_req && (cnt0 == wait_n);
    assign bus0.imem_rdata = mem(bus0.imem_addr);

    always @(posedge clk) begin
        if (rst || !bus0.imem_req || bus0.imem_ack) cnt0 <= 0;
        else                                         cnt0 <= cnt0 + 1;
    end

    fetch_stage #(.RESET_PC(32'h0)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus0.master),
        .instruction(instruction), .inst_valid(inst_valid),
        .inst_pc(inst_pc), .pc_plus4(pc_plus4)
    );

    // ---------------- DUT1: wrap-around RESET_PC, zero-wait memory
    logic        rst1, stall1, redirect1;
    logic [31:0] redirect_pc1;
    logic [31:0] instruction1, inst_pc1, pc_plus41;
    logic        inst_valid1;

    fetch_stage_if bus1();

    assign bus1.imem_ack   = bus1.imem_req;
    assign bus1.imem_rdata = mem(bus1.imem_addr);

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst1), .stall(stall1), .redirect(redirect1),
        .redirect_pc(redirect_pc1), .imem(bus1.master),
        .instruction(instruction1), .inst_valid(inst_valid1),
        .inst_pc(inst_pc1), .pc_plus4(pc_plus41)
    );

    // ---------------- vector table
    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc;
        int          w;
        bit          chk;     // check registered outputs and address
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_ipc, e_p4;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input int w, input bit c, input logic rq, input logic [31:0] a,
                       input logic v, input logic [31:0] ipc, input logic [31:0] p4);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = rd; x.rpc = rpc; x.w = w; x.chk = c;
        x.e_req = rq; x.e_addr = a; x.e_v = v; x.e_ipc = ipc; x.e_p4 = p4;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; wait_n = 0;
        rst1 = 1'b1; stall1 = 1'b0; redirect1 = 1'b0; redirect_pc1 = 32'h0;

        //   rst st rd rpc        w  chk req addr          v  ipc           p4
        // A: zero-wait stream, stall on 0x8, redirect under stall to 0x103
        add(1, 0, 0, 32'h0,     0, 0, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,     0, 1, 0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h4,        1, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h8,        1, 32'h4,        32'h8);
        add(0, 1, 0, 32'h0,     0, 1, 0, 32'hC,        1, 32'h8,        32'hC);
        add(0, 1, 0, 32'h0,     0, 1, 0, 32'hC,        1, 32'h8,        32'hC);
        add(0, 1, 0, 32'h0,     0, 1, 0, 32'hC,        1, 32'h8,        32'hC);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'hC,        1, 32'h8,        32'hC);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h10,       1, 32'hC,        32'h10);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h14,       1, 32'h10,       32'h14);
        add(0, 1, 1, 32'h103,   0, 1, 0, 32'h18,       1, 32'h14,       32'h18);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h100,      0, 32'h14,       32'h18);
        add(0, 0, 0, 32'h0,     0, 1, 1, 32'h104,      1, 32'h100,      32'h104);
        // B: 3 wait states, request held 4 cycles
        add(1, 0, 0, 32'h0,     3, 0, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,     3, 1, 0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h4,        1, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h4,        0, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h4,        0, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h4,        0, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h8,        1, 32'h4,        32'h8);
        // C: 2 wait states, redirect to 0x100 while 0x8 is in flight
        add(1, 0, 0, 32'h0,     2, 0, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,     2, 1, 0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h4,        1, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h4,        0, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h4,        0, 32'h0,        32'h4);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h8,        1, 32'h4,        32'h8);
        add(0, 0, 1, 32'h100,   2, 1, 1, 32'h8,        0, 32'h4,        32'h8);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h8,        0, 32'h4,        32'h8);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h100,      0, 32'h4,        32'h8);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h100,      0, 32'h4,        32'h8);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h100,      0, 32'h4,        32'h8);
        add(0, 0, 0, 32'h0,     2, 1, 1, 32'h104,      1, 32'h100,      32'h104);
        // D: 3 wait states; idle redirect, then two redirects during DROP
        add(1, 0, 0, 32'h0,     3, 0, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,     3, 1, 0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 1, 32'h40,    3, 1, 0, 32'h0,        0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h40,       0, 32'h0,        32'h0);
        add(0, 0, 1, 32'h80,    3, 1, 1, 32'h40,       0, 32'h0,        32'h0);
        add(0, 0, 1, 32'hC4,    3, 1, 1, 32'h40,       0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'h40,       0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'hC4,       0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'hC4,       0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'hC4,       0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'hC4,       0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,     3, 1, 1, 32'hC8,       1, 32'hC4,       32'hC8);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc; wait_n = vecs[i].w;
            #1;
            chk($sformatf("row%0d imem_req", i), {31'h0, bus0.imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].chk) begin
                chk($sformatf("row%0d imem_addr", i), bus0.imem_addr, vecs[i].e_addr);
                chk($sformatf("row%0d inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].e_v});
                chk($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
                chk($sformatf("row%0d pc_plus4", i), pc_plus4, vecs[i].e_p4);
                chk($sformatf("row%0d instruction", i), instruction,
                    vecs[i].e_v ? mem(vecs[i].e_ipc) : 32'h0);
            end
        end

        // Wrap-around fetch from 0xFFFF_FFF8 on the second instance.
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        chk("wrap0 imem_req", {31'h0, bus1.imem_req}, 32'h1);
        chk("wrap0 imem_addr", bus1.imem_addr, 32'hFFFF_FFF8);
        chk("wrap0 inst_valid", {31'h0, inst_valid1}, 32'h0);
        @(negedge clk); #1;
        chk("wrap1 imem_addr", bus1.imem_addr, 32'hFFFF_FFFC);
        chk("wrap1 inst_pc", inst_pc1, 32'hFFFF_FFF8);
        chk("wrap1 pc_plus4", pc_plus41, 32'hFFFF_FFFC);
        chk("wrap1 instruction", instruction1, mem(32'hFFFF_FFF8));
        @(negedge clk); #1;
        chk("wrap2 imem_addr", bus1.imem_addr, 32'h0);
        chk("wrap2 inst_pc", inst_pc1, 32'hFFFF_FFFC);
        chk("wrap2 pc_plus4", pc_plus41, 32'h0);
        chk("wrap2 inst_valid", {31'h0, inst_valid1}, 32'h1);
        @(negedge clk); #1;
        chk("wrap3 imem_addr", bus1.imem_addr, 32'h4);
        chk("wrap3 inst_pc", inst_pc1, 32'h0);
        chk("wrap3 pc_plus4", pc_plus41, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage MIPS pipeline. It owns the fetch PC, issues word requests to instruction memory over a req/ack handshake that tolerates wait states, and presents one fetched instruction per cycle to the IF/ID pipeline register. It also honours hazard-unit stalls and control-flow redirects from decode, including redirects that arrive while a memory request is still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: IF/ID must not take the presented instruction this cycle.
- redirect  in  1  branch taken or jump resolved this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word address of the request.
- imem_ack  in  1  the request completes at this edge; imem_rdata is valid.
- imem_rdata  in  32  instruction word.
- instruction  out  32  presented instruction; 32'h0 (nop) whenever inst_valid=0.
- inst_valid  out  1  instruction is a real fetched word.
- inst_pc  out  32  address of the presented instruction.
- pc_plus4  out  32  inst_pc+4, registered together with inst_pc.

## Operation
- Registers:
  - pc: next fetch address.
  - busy: a request is outstanding.
  - drop: the outstanding request is on the wrong path.
  - pend_pc: redirect target saved during drop.
  - Output registers: instruction, inst_valid, inst_pc, pc_plus4.
- imem_addr = pc at all times. pc never changes while busy or drop is set.
- issue = !busy && !drop && !redirect && (!inst_valid || !stall).
- imem_req = !rst && (busy || drop || issue).
  - Once asserted, imem_req and imem_addr stay asserted and stable until imem_ack. There is no abort.
- States:
  - IDLE: busy=0, drop=0.
  - BUSY: busy=1.
  - DROP: drop=1.
- Edge with imem_req=1 and imem_ack=1:
  - If drop=1 or redirect=1, the data is discarded and the stage goes to IDLE. pc <= redirect_pc if redirect=1, otherwise pend_pc.
  - Otherwise: instruction <= imem_rdata, inst_pc <= pc, pc_plus4 <= pc+4, inst_valid <= 1, pc <= pc+4, and the stage goes to IDLE.
- Edge with imem_req=1 and imem_ack=0:
  - If redirect=1: go to DROP, pend_pc <= redirect_pc. A newer redirect while already in DROP overwrites pend_pc.
  - Otherwise go to (or stay in) BUSY.
- Redirect with imem_req=0: pc <= redirect_pc.
- Consumption: an edge with inst_valid=1 and stall=0 consumes the presented instruction. inst_valid goes to 0 unless an ack refills the slot at the same edge.
- Redirect overrides stall. At the redirect edge inst_valid <= 0, which kills the wrong-path instruction and causes IF/ID to load a nop.
- A request is only issued while the output slot is empty or being consumed. An ack therefore never finds the slot full, and no skid buffer is needed.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- During rst, and at the edge where rst is sampled high:
  - pc = RESET_PC, pend_pc = 0.
  - busy = drop = 0.
  - inst_valid = 0, instruction = 0, inst_pc = 0, pc_plus4 = 0.
  - imem_req is forced to 0 while rst=1.
- First request: the first cycle with rst=0 drives imem_addr = RESET_PC.
- Fetch latency: request cycle plus N wait cycles; inst_valid rises at the ack edge. A zero-wait memory (ack tied high) gives one instruction per cycle with no bubbles while stall=0.
- Redirect penalty with no request in flight: one cycle with imem_req=0, then the target is requested.
- Redirect with a request in flight: the old request runs to completion, its data is discarded, and the target is requested the cycle after the old ack.
- rst during BUSY or DROP abandons the transaction. Memory is required to drop any pending ack on rst.

## Test plan
- Reset, RESET_PC=0, ack tied 1, stall=0 -> imem_addr 0,4,8,C on consecutive cycles; inst_pc 0,4,8 one cycle behind each request; inst_valid stays 1 continuously.
- Ack 3 cycles after each request -> imem_req held with a stable address for 4 cycles; inst_valid pulses once every 4 cycles; pc_plus4 = inst_pc+4.
- Zero-wait memory; stall=1 for 3 cycles while inst_pc=0x8 is presented -> instruction and inst_pc hold and imem_req=0; 0xC is requested on the stall-release cycle and presented at the next edge.
- 2-wait memory; redirect to 0x100 the cycle after 0x8 is requested -> 0x8 held until ack, its data dropped, 0x100 requested next cycle; inst_valid=0 until 0x100 data arrives.
- redirect=1 with stall=1 in the same cycle, redirect_pc=0x103 -> inst_valid=0 and instruction=0 next cycle; next request address is 0x100.
- RESET_PC=0xFFFF_FFF8, zero-wait memory -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc_plus4 of the last word = 0x0.
